data_memory_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 16-bit data memory. It shares the single memory port between the CPU core and a host port (program loader / debug). It grants one access at a time with round-robin fairness and drives the memory's write-enable, address and write-data lines. It captures the memory's falling-edge read data, returns it with a one-cycle acknowledge, and blocks out-of-range accesses.

---
 rtl/data_memory_arbiter.sv | 154 +++++++++++++++
 tb/tb_data_memory_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter and sequencer that shares the single data-memory port
// between the CPU core and the host port, with range checking and one-cycle acks.
module data_memory_arbiter #(
  parameter int DEPTH  = 513,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_err,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_e;

  // One extra bit so DEPTH itself is representable even when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic                last_host_q, last_host_d;
  logic                win_host_q, win_host_d;
  logic                oor_q, oor_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                core_ack_q, core_ack_d, core_err_q, core_err_d;
  logic                host_ack_q, host_ack_d, host_err_q, host_err_d;
  logic [DATA_W-1:0]   core_rdata_q, core_rdata_d, host_rdata_q, host_rdata_d;

  logic                grant_host;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_oor;
  logic [DATA_W-1:0]   ret_data;

  // Host wins when it is the only requester, or on a tie when the core went last.
  assign grant_host = host_req && (!core_req || !last_host_q);
  assign sel_we     = grant_host ? host_we    : core_we;
  assign sel_addr   = grant_host ? host_addr  : core_addr;
  assign sel_wdata  = grant_host ? host_wdata : core_wdata;
  assign sel_oor    = ({1'b0, sel_addr} >= DEPTH_W);

  // Only an in-range read returns memory data; writes and rejected accesses return 0.
  assign ret_data = (!mem_we_q && !oor_q) ? mem_data_out : '0;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    state_d      = state_q;
    last_host_d  = last_host_q;
    win_host_d   = win_host_q;
    oor_d        = oor_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_ack_d   = 1'b0;
    core_err_d   = 1'b0;
    core_rdata_d = '0;
    host_ack_d   = 1'b0;
    host_err_d   = 1'b0;
    host_rdata_d = '0;

    unique case (state_q)
      IDLE: begin
        if (core_req || host_req) begin
          win_host_d  = grant_host;
          oor_d       = sel_oor;
          mem_we_d    = sel_we && !sel_oor;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        last_host_d = win_host_q;
        if (win_host_q) begin
          host_ack_d   = 1'b1;
          host_err_d   = oor_q;
          host_rdata_d = ret_data;
        end else begin
          core_ack_d   = 1'b1;
          core_err_d   = oor_q;
          core_rdata_d = ret_data;
        end
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the same pre-edge values; reset starts last_grant at host so the core wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_host_q  <= 1'b1;
      win_host_q   <= 1'b0;
      oor_q        <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_ack_q   <= 1'b0;
      core_err_q   <= 1'b0;
      core_rdata_q <= '0;
      host_ack_q   <= 1'b0;
      host_err_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_host_q  <= last_host_d;
      win_host_q   <= win_host_d;
      oor_q        <= oor_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_ack_q   <= core_ack_d;
      core_err_q   <= core_err_d;
      core_rdata_q <= core_rdata_d;
      host_ack_q   <= host_ack_d;
      host_err_q   <= host_err_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_wdata_q;
  assign core_ack    = core_ack_q;
  assign core_err    = core_err_q;
  assign core_rdata  = core_rdata_q;
  assign host_ack    = host_ack_q;
  assign host_err    = host_err_q;
  assign host_rdata  = host_rdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: a falling-edge memory device plus a transaction-level
// model (tie-break alternation, golden memory image, fixed ack timing) checked every cycle.
module tb_data_memory_arbiter;

  localparam int DEPTH = 513;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we, host_req, host_we;
  logic [15:0] core_addr, core_wdata, host_addr, host_wdata;
  logic        core_ack, core_err, host_ack, host_err;
  logic [15:0] core_rdata, host_rdata;
  logic        mem_we, busy;
  logic [15:0] mem_addr, mem_data_in, mem_data_out;

  int vectors = 0;
  int miscompares = 0;

  bit [15:0] dev_mem [DEPTH];
  bit [15:0] exp_mem [DEPTH];
  bit        last_host;

  data_memory_arbiter #(.DEPTH(DEPTH), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_rdata(core_rdata), .core_err(core_err),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Falling-edge memory; out-of-range reads return a marker the arbiter must suppress.
  always @(negedge clk) begin
    if (mem_we && mem_addr < DEPTH) dev_mem[mem_addr] <= mem_data_in;
    mem_data_out <= (mem_addr < DEPTH) ? dev_mem[mem_addr] : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Golden memory effect of one access; returns the data the requester should see.
  function automatic logic [15:0] serve(input bit we, input logic [15:0] addr, input logic [15:0] wd);
    if (addr >= DEPTH) return 16'h0;
    if (we) begin
      exp_mem[addr] = wd;
      return 16'h0;
    end
    return exp_mem[addr];
  endfunction

  // One arbitration round: either or both requesters, checked cycle by cycle.
  task automatic xact(input bit c_en, input bit c_we, input logic [15:0] c_addr, input logic [15:0] c_wd,
                      input bit h_en, input bit h_we, input logic [15:0] h_addr, input logic [15:0] h_wd);
    bit          first_host, c_oor, h_oor, exp_c, exp_h, we_c, we_h;
    int          c_t, h_t, n;
    logic [15:0] c_rd, h_rd;
    c_rd = '0;
    h_rd = '0;
    first_host = (c_en && h_en) ? !last_host : h_en;
    n     = (c_en && h_en) ? 6 : 3;
    c_t   = !c_en ? 0 : (first_host ? 5 : 2);
    h_t   = !h_en ? 0 : (first_host ? 2 : 5);
    c_oor = (c_addr >= DEPTH);
    h_oor = (h_addr >= DEPTH);
    if (first_host) begin
      if (h_en) h_rd = serve(h_we, h_addr, h_wd);
      if (c_en) c_rd = serve(c_we, c_addr, c_wd);
    end else begin
      if (c_en) c_rd = serve(c_we, c_addr, c_wd);
      if (h_en) h_rd = serve(h_we, h_addr, h_wd);
    end
    last_host = (c_en && h_en) ? !first_host : h_en;

    core_req = c_en; core_we = c_we; core_addr = c_addr; core_wdata = c_wd;
    host_req = h_en; host_we = h_we; host_addr = h_addr; host_wdata = h_wd;
    for (int t = 1; t <= n; t++) begin
      tick();
      exp_c = c_en && (t == c_t);
      exp_h = h_en && (t == h_t);
      check("core_ack",   core_ack,   exp_c);
      check("core_err",   core_err,   exp_c && c_oor);
      check("core_rdata", core_rdata, exp_c ? c_rd : 16'h0);
      check("host_ack",   host_ack,   exp_h);
      check("host_err",   host_err,   exp_h && h_oor);
      check("host_rdata", host_rdata, exp_h ? h_rd : 16'h0);
      check("busy",       busy,       (t % 3) != 0);
      we_c = c_en && (t == c_t - 1) && c_we && !c_oor;
      we_h = h_en && (t == h_t - 1) && h_we && !h_oor;
      check("mem_we", mem_we, we_c || we_h);
      if (c_en && t == c_t - 1) begin
        check("mem_addr_core",  mem_addr,    c_addr);
        check("mem_wdata_core", mem_data_in, c_wd);
      end
      if (h_en && t == h_t - 1) begin
        check("mem_addr_host",  mem_addr,    h_addr);
        check("mem_wdata_host", mem_data_in, h_wd);
      end
      if (exp_c) core_req = 1'b0;
      if (exp_h) host_req = 1'b0;
    end
  endtask

  initial begin
    bit          c_en, h_en;
    logic [15:0] ca, ha;
    rst_n = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    last_host = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {mem_we, mem_addr, mem_data_in, core_ack, core_rdata, core_err,
                          host_ack, host_rdata, host_err, busy}, 32'h0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_rdata", {core_rdata, host_rdata}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Tie right after reset goes to the core.
    xact(1, 1, 16'd1, 16'h1111, 1, 1, 16'd2, 16'h2222);
    xact(1, 1, 16'd5, 16'h1234, 0, 0, 16'd0, 16'h0);
    xact(1, 0, 16'd5, 16'h0000, 0, 0, 16'd0, 16'h0);
    // Core went last, so this tie goes to the host.
    xact(1, 0, 16'd1, 16'h0, 1, 0, 16'd2, 16'h0);
    xact(0, 0, 16'd0, 16'h0, 1, 1, 16'd513, 16'hBEEF);
    xact(0, 0, 16'd0, 16'h0, 1, 0, 16'd513, 16'h0);
    xact(1, 1, 16'd512, 16'hA5A5, 0, 0, 16'd0, 16'h0);
    xact(0, 0, 16'd0, 16'h0, 1, 0, 16'd512, 16'h0);

    // Core request held across three back-to-back reads.
    core_req = 1'b1; core_we = 1'b0; core_addr = 16'd5;
    for (int t = 1; t <= 9; t++) begin
      tick();
      check("held_ack",   core_ack,   (t % 3) == 2);
      check("held_busy",  busy,       (t % 3) != 0);
      check("held_rdata", core_rdata, ((t % 3) == 2) ? exp_mem[5] : 16'h0);
      if (t == 8) core_req = 1'b0;
    end
    last_host = 1'b0;

    // Reset during ACCESS, before the falling edge: the write must not land.
    xact(1, 1, 16'd7, 16'h0707, 0, 0, 16'd0, 16'h0);
    core_req = 1'b1; core_we = 1'b1; core_addr = 16'd7; core_wdata = 16'h7777;
    tick();
    check("pre_rst_mem_we", mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", {mem_we, core_ack, core_err, host_ack, host_err, busy}, 32'h0);
    check("mid_rst_bus", {mem_addr, mem_data_in}, 32'h0);
    check("mid_rst_rdata", {core_rdata, host_rdata}, 32'h0);
    core_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    last_host = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      check("post_rst_no_ack", {core_ack, host_ack, busy}, 32'h0);
    end
    xact(1, 0, 16'd7, 16'h0, 0, 0, 16'd0, 16'h0);

    // Randomized rounds around the bottom of memory and the range boundary.
    for (int i = 0; i < 40; i++) begin
      c_en = 1'($urandom);
      h_en = 1'($urandom);
      if (!c_en && !h_en) c_en = 1'b1;
      ca = $urandom_range(0, 1) ? 16'($urandom_range(0, 15)) : 16'($urandom_range(DEPTH - 4, DEPTH + 3));
      ha = $urandom_range(0, 1) ? 16'($urandom_range(0, 15)) : 16'($urandom_range(DEPTH - 4, DEPTH + 3));
      xact(c_en, 1'($urandom), ca, 16'($urandom), h_en, 1'($urandom), ha, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
